// File: rtl/cpu_status_unit.sv
// Status/termination unit: detects HALT or decode errors in ID, freezes issue,
// drains the pipeline, then parks in HALTED or ERROR. Also keeps saturating
// cycle and retired-instruction counters.
module cpu_status_unit #(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [PC_WIDTH-1:0]  id_pc,
  input  logic                 id_halt,
  input  logic                 id_bad_opcode,
  input  logic                 id_bad_funct,
  input  logic                 stall_in,
  input  logic                 wb_retire,
  output logic                 freeze,
  output logic                 halted,
  output logic                 error,
  output logic [1:0]           error_code,
  output logic [PC_WIDTH-1:0]  error_pc,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StError} state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   err_pending_q, err_pending_d;
  logic [1:0]             code_q, code_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   halted_q, error_q;
  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic                   accept;
  logic                   has_err;
  logic                   active;

  assign has_err = id_bad_opcode | id_bad_funct;
  assign accept  = (state_q == StRun) & id_valid & ~stall_in & (id_halt | has_err);
  // Accepting instruction already blocks the next one from issuing.
  assign freeze  = (state_q != StRun) | accept;
  assign active  = (state_q == StRun) | (state_q == StDrain);

  // Next-state logic: termination FSM, drain countdown and error latches.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    err_pending_d = err_pending_q;
    code_d        = code_q;
    pc_d          = pc_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          state_d       = StDrain;
          drain_d       = DW'(DRAIN_CYCLES - 1);
          // Error wins over a simultaneous HALT.
          err_pending_d = has_err;
          if (has_err) begin
            code_d = {id_bad_funct, id_bad_opcode};
            pc_d   = id_pc;
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = err_pending_q ? StError : StHalted;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Saturating counters, frozen once the unit has parked.
  always_comb begin
    cycle_d   = cycle_q;
    retired_d = retired_q;
    if (active && (cycle_q != '1)) begin
      cycle_d = cycle_q + 1'b1;
    end
    if (active && wb_retire && (retired_q != '1)) begin
      retired_d = retired_q + 1'b1;
    end
  end

  // State register; halted/error are flopped from the parked state, so they
  // rise one edge after the FSM leaves DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      drain_q       <= '0;
      err_pending_q <= 1'b0;
      code_q        <= 2'b00;
      pc_q          <= '0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
      cycle_q       <= '0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      err_pending_q <= err_pending_d;
      code_q        <= code_d;
      pc_q          <= pc_d;
      halted_q      <= (state_q == StHalted);
      error_q       <= (state_q == StError);
      cycle_q       <= cycle_d;
      retired_q     <= retired_d;
    end
  end

  assign halted        = halted_q;
  assign error         = error_q;
  assign error_code    = code_q;
  assign error_pc      = pc_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule
